// File: rtl/hazard_scoreboard.sv
// D-stage hazard unit: tracks in-flight destinations and Tnew per stage,
// raises stall against Tuse, picks D-stage forward sources, gates HI/LO users.
module hazard_scoreboard #(
  parameter int STAGES    = 3,
  parameter int ADDR_W    = 5,
  parameter int T_W       = 3,
  parameter int MD_CYCLES = 5,
  parameter int SEL_W     = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              d_valid,
  input  logic [ADDR_W-1:0] d_rs,
  input  logic [ADDR_W-1:0] d_rt,
  input  logic [T_W-1:0]    d_tuse_rs,
  input  logic [T_W-1:0]    d_tuse_rt,
  input  logic [ADDR_W-1:0] d_wa,
  input  logic [T_W-1:0]    d_tnew,
  input  logic              d_md_start,
  input  logic              d_md_use,
  output logic              stall,
  output logic [SEL_W-1:0]  fwd_rs_sel,
  output logic [SEL_W-1:0]  fwd_rt_sel,
  output logic              md_busy
);

  localparam int CNT_W = $clog2(MD_CYCLES + 1);

  typedef struct packed {
    logic              valid;
    logic [ADDR_W-1:0] wa;
    logic [T_W-1:0]    tnew;
  } entry_t;

  entry_t            ent [STAGES];
  logic [CNT_W-1:0]  cnt;

  logic              hit_rs;
  logic              hit_rt;
  logic [T_W-1:0]    tnew_rs;
  logic [T_W-1:0]    tnew_rt;
  logic [SEL_W-1:0]  idx_rs;
  logic [SEL_W-1:0]  idx_rt;
  logic              hazard_rs;
  logic              hazard_rt;
  logic              hazard_md;
  logic              accept;

  // Scan oldest to youngest so the youngest match is written last and wins.
  always_comb begin
    hit_rs  = 1'b0;
    hit_rt  = 1'b0;
    tnew_rs = '0;
    tnew_rt = '0;
    idx_rs  = '0;
    idx_rt  = '0;
    for (int i = STAGES - 1; i >= 0; i--) begin
      if (ent[i].valid && ent[i].wa == d_rs && d_rs != '0) begin
        hit_rs  = 1'b1;
        tnew_rs = ent[i].tnew;
        idx_rs  = SEL_W'(i + 1);
      end
      if (ent[i].valid && ent[i].wa == d_rt && d_rt != '0) begin
        hit_rt  = 1'b1;
        tnew_rt = ent[i].tnew;
        idx_rt  = SEL_W'(i + 1);
      end
    end
  end

  always_comb begin
    hazard_rs = d_valid & hit_rs & (tnew_rs > d_tuse_rs);
    hazard_rt = d_valid & hit_rt & (tnew_rt > d_tuse_rt);
    md_busy   = (cnt != '0);
    hazard_md = d_valid & d_md_use & md_busy;
    stall     = hazard_rs | hazard_rt | hazard_md;
    accept    = d_valid & ~stall;
  end

  always_comb begin
    fwd_rs_sel = '0;
    fwd_rt_sel = '0;
    if (hit_rs && tnew_rs == '0) fwd_rs_sel = idx_rs;
    if (hit_rt && tnew_rt == '0) fwd_rt_sel = idx_rt;
  end

  // Stages past D never freeze; a stall only turns the E entry into a bubble.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < STAGES; i++) begin
        ent[i] <= '0;
      end
    end else begin
      if (accept) begin
        ent[0].valid <= 1'b1;
        ent[0].wa    <= d_wa;
        ent[0].tnew  <= d_tnew;
      end else begin
        ent[0] <= '0;
      end
      for (int i = 1; i < STAGES; i++) begin
        ent[i].valid <= ent[i-1].valid;
        ent[i].wa    <= ent[i-1].wa;
        ent[i].tnew  <= (ent[i-1].tnew == '0) ? '0
                      : ent[i-1].tnew - T_W'(1);
      end
    end
  end

  // A stalled mult/div start must not reload the busy counter.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt <= '0;
    end else if (d_md_start && accept) begin
      cnt <= CNT_W'(MD_CYCLES);
    end else if (cnt != '0) begin
      cnt <= cnt - CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed bench for hazard_scoreboard (STAGES=3, MD_CYCLES=5).
// Inputs change 1 time unit after the rising edge; outputs sampled 1 unit later.
module tb_hazard_scoreboard;

  logic       clk;
  logic       reset;
  logic       d_valid;
  logic [4:0] d_rs;
  logic [4:0] d_rt;
  logic [2:0] d_tuse_rs;
  logic [2:0] d_tuse_rt;
  logic [4:0] d_wa;
  logic [2:0] d_tnew;
  logic       d_md_start;
  logic       d_md_use;
  logic       stall;
  logic [1:0] fwd_rs_sel;
  logic [1:0] fwd_rt_sel;
  logic       md_busy;

  int n_cmp = 0;
  int n_err = 0;

  hazard_scoreboard #(
    .STAGES(3), .ADDR_W(5), .T_W(3), .MD_CYCLES(5), .SEL_W(2)
  ) dut (
    .clk(clk), .reset(reset), .d_valid(d_valid),
    .d_rs(d_rs), .d_rt(d_rt),
    .d_tuse_rs(d_tuse_rs), .d_tuse_rt(d_tuse_rt),
    .d_wa(d_wa), .d_tnew(d_tnew),
    .d_md_start(d_md_start), .d_md_use(d_md_use),
    .stall(stall), .fwd_rs_sel(fwd_rs_sel),
    .fwd_rt_sel(fwd_rt_sel), .md_busy(md_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [4:0] rs,
                       input logic [4:0] rt, input logic [2:0] urs,
                       input logic [2:0] urt, input logic [4:0] wa,
                       input logic [2:0] tn, input logic ms,
                       input logic mu);
    d_valid = v; d_rs = rs; d_rt = rt;
    d_tuse_rs = urs; d_tuse_rt = urt;
    d_wa = wa; d_tnew = tn;
    d_md_start = ms; d_md_use = mu;
    #1;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    for (int k = 0; k < n; k++) step();
  endtask

  initial begin
    reset = 1'b1;
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    step();
    step();
    reset = 1'b0;
    check("rst_stall", stall, 0);
    check("rst_rs_sel", fwd_rs_sel, 0);
    check("rst_rt_sel", fwd_rt_sel, 0);
    check("rst_md_busy", md_busy, 0);

    // lw $2 tnew=2, then consumer rs=2 tuse=1
    drive(1, 0, 0, 0, 0, 2, 2, 0, 0);
    check("lw_issue_stall", stall, 0);
    step();
    drive(1, 2, 0, 1, 3, 0, 0, 0, 0);
    check("lw_use_stall", stall, 1);
    check("lw_use_sel", fwd_rs_sel, 0);
    step();
    drive(1, 2, 0, 1, 3, 0, 0, 0, 0);
    check("lw_use_go", stall, 0);
    check("lw_use_go_sel", fwd_rs_sel, 0);
    step();
    idle(3);

    // ori $3 tnew=1, then beq rs=3 tuse=0
    drive(1, 0, 0, 0, 0, 3, 1, 0, 0);
    step();
    drive(1, 3, 0, 0, 3, 0, 0, 0, 0);
    check("beq_stall", stall, 1);
    step();
    drive(1, 3, 0, 0, 3, 0, 0, 0, 0);
    check("beq_go", stall, 0);
    check("beq_sel", fwd_rs_sel, 2);
    step();
    idle(3);

    // two writers of $4, both ready; youngest (entry0) wins
    drive(1, 0, 0, 0, 0, 4, 1, 0, 0);
    step();
    drive(1, 0, 0, 0, 0, 4, 0, 0, 0);
    check("dup_issue_stall", stall, 0);
    step();
    drive(1, 0, 4, 3, 0, 0, 0, 0, 0);
    check("dup_stall", stall, 0);
    check("dup_rt_sel", fwd_rt_sel, 1);
    check("dup_rs_sel", fwd_rs_sel, 0);
    step();
    idle(3);

    // $0 never matches
    drive(1, 0, 0, 0, 0, 0, 3, 0, 0);
    step();
    drive(1, 0, 0, 0, 0, 0, 0, 0, 0);
    check("zero_stall", stall, 0);
    check("zero_sel", fwd_rs_sel, 0);
    step();
    idle(3);

    // older ready match ignored behind a young slow one; drop-off
    drive(1, 0, 0, 0, 0, 5, 1, 0, 0);
    step();
    drive(1, 0, 0, 0, 0, 5, 3, 0, 0);
    step();
    drive(1, 5, 0, 0, 3, 0, 0, 0, 0);
    check("young_stall_a", stall, 1);
    check("young_sel_a", fwd_rs_sel, 0);
    step();
    check("young_stall_b", stall, 1);
    check("young_sel_b", fwd_rs_sel, 0);
    step();
    check("young_stall_c", stall, 1);
    drive(0, 5, 0, 0, 3, 0, 0, 0, 0);
    check("invalid_no_stall", stall, 0);
    drive(1, 5, 0, 0, 3, 0, 0, 0, 0);
    step();
    check("dropoff_stall", stall, 0);
    check("dropoff_sel", fwd_rs_sel, 0);
    step();
    idle(3);

    // mult at t, HI/LO users stall t+1..t+5; stalled mult does not reload
    drive(1, 0, 0, 0, 0, 0, 0, 1, 1);
    check("mult_issue_stall", stall, 0);
    check("mult_issue_busy", md_busy, 0);
    step();
    for (int k = 1; k <= 5; k++) begin
      if (k <= 3) drive(1, 0, 0, 0, 0, 8, 1, 0, 1);
      else        drive(1, 0, 0, 0, 0, 0, 0, 1, 1);
      check($sformatf("md_busy_t%0d", k), md_busy, 1);
      check($sformatf("md_stall_t%0d", k), stall, 1);
      step();
    end
    drive(1, 0, 0, 0, 0, 8, 1, 0, 1);
    check("md_busy_t6", md_busy, 0);
    check("md_stall_t6", stall, 0);
    step();
    idle(3);

    // lw pending, cnt=3, then reset for one cycle
    drive(1, 0, 0, 0, 0, 0, 0, 1, 1);
    step();
    drive(1, 0, 0, 0, 0, 2, 2, 0, 0);
    step();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    step();
    drive(1, 2, 2, 0, 0, 0, 0, 0, 1);
    check("pre_rst_stall", stall, 1);
    check("pre_rst_busy", md_busy, 1);
    reset = 1'b1;
    step();
    reset = 1'b0;
    #1;
    check("post_rst_stall", stall, 0);
    check("post_rst_busy", md_busy, 0);
    check("post_rst_rs_sel", fwd_rs_sel, 0);
    check("post_rst_rt_sel", fwd_rt_sel, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end

endmodule
